// File: rtl/tdm_demux_1x4.sv
// rtl/tdm_demux_1x4.sv - 4-channel TDM demultiplexer with SOF alignment, gap timeout and lock tracking.
module tdm_demux_1x4 #(
    parameter int WIDTH     = 4,
    parameter int GAP_LIMIT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_sof,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] d1,
    output logic [WIDTH-1:0] d2,
    output logic [WIDTH-1:0] d3,
    output logic [WIDTH-1:0] d4,
    output logic             frame_valid,
    output logic [1:0]       slot,
    output logic             locked,
    output logic             sync_err,
    output logic             timeout_err
);

    localparam int GAP_W = $clog2(GAP_LIMIT + 1);

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        COLLECT = 2'd1,
        ALIGNED = 2'd2
    } state_t;

    state_t             state, state_next;
    logic [GAP_W-1:0]   gap, gap_next, gap_inc;
    logic [WIDTH-1:0]   shadow      [0:2];
    logic [WIDTH-1:0]   shadow_next [0:2];
    logic [WIDTH-1:0]   d1_next, d2_next, d3_next, d4_next;
    logic [1:0]         slot_next;
    logic               frame_valid_next, locked_next, sync_err_next, timeout_err_next;
    logic               accept_sof, accept_data, gap_hit;

    assign accept_sof  = in_valid && in_sof;
    assign accept_data = in_valid && !in_sof;
    // Saturating increment; gap_hit fires when this idle cycle would reach the limit.
    assign gap_inc     = (gap == {GAP_W{1'b1}}) ? gap : gap + GAP_W'(1);
    assign gap_hit     = (gap_inc >= GAP_W'(GAP_LIMIT));

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= HUNT;
            slot        <= 2'd0;
            gap         <= '0;
            d1          <= '0;
            d2          <= '0;
            d3          <= '0;
            d4          <= '0;
            frame_valid <= 1'b0;
            locked      <= 1'b0;
            sync_err    <= 1'b0;
            timeout_err <= 1'b0;
            for (int i = 0; i < 3; i++) shadow[i] <= '0;
        end else begin
            state       <= state_next;
            slot        <= slot_next;
            gap         <= gap_next;
            d1          <= d1_next;
            d2          <= d2_next;
            d3          <= d3_next;
            d4          <= d4_next;
            frame_valid <= frame_valid_next;
            locked      <= locked_next;
            sync_err    <= sync_err_next;
            timeout_err <= timeout_err_next;
            for (int i = 0; i < 3; i++) shadow[i] <= shadow_next[i];
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            HUNT: begin
                if (accept_sof) state_next = COLLECT;
            end
            COLLECT: begin
                if (accept_data && slot == 2'd3)  state_next = ALIGNED;
                else if (!in_valid && gap_hit)    state_next = HUNT;
            end
            ALIGNED: begin
                if (accept_sof)       state_next = COLLECT;
                else if (accept_data) state_next = HUNT;
            end
            default: state_next = HUNT;
        endcase
    end

    always_comb begin
        slot_next        = slot;
        gap_next         = '0;
        d1_next          = d1;
        d2_next          = d2;
        d3_next          = d3;
        d4_next          = d4;
        frame_valid_next = 1'b0;
        locked_next      = locked;
        sync_err_next    = 1'b0;
        timeout_err_next = 1'b0;
        for (int i = 0; i < 3; i++) shadow_next[i] = shadow[i];

        case (state)
            COLLECT: begin
                if (accept_sof) begin
                    // Early SOF restarts the frame with this word as slot 0.
                    sync_err_next  = 1'b1;
                    locked_next    = 1'b0;
                    shadow_next[0] = in_data;
                    slot_next      = 2'd1;
                end else if (accept_data) begin
                    if (slot == 2'd3) begin
                        d1_next          = shadow[0];
                        d2_next          = shadow[1];
                        d3_next          = shadow[2];
                        d4_next          = in_data;
                        frame_valid_next = 1'b1;
                        locked_next      = 1'b1;
                        slot_next        = 2'd0;
                    end else begin
                        for (int i = 0; i < 3; i++)
                            if (slot == 2'(i)) shadow_next[i] = in_data;
                        slot_next = slot + 2'd1;
                    end
                end else if (gap_hit) begin
                    timeout_err_next = 1'b1;
                    locked_next      = 1'b0;
                    slot_next        = 2'd0;
                end else begin
                    gap_next = gap_inc;
                end
            end
            default: begin
                slot_next = 2'd0;
                if (accept_sof) begin
                    shadow_next[0] = in_data;
                    slot_next      = 2'd1;
                end else if (accept_data && state == ALIGNED) begin
                    sync_err_next = 1'b1;
                    locked_next   = 1'b0;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_tdm_demux_1x4.sv
// tb/tb_tdm_demux_1x4.sv - Randomized and directed bench for tdm_demux_1x4 against a queue-based frame model.
module tb_tdm_demux_1x4;

    localparam int W   = 4;
    localparam int GAP = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_sof = 1'b0;
    logic [W-1:0] in_data = '0;
    logic [W-1:0] d1, d2, d3, d4;
    logic         frame_valid, locked, sync_err, timeout_err;
    logic [1:0]   slot;

    tdm_demux_1x4 #(.WIDTH(W), .GAP_LIMIT(GAP)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data),
        .d1(d1), .d2(d2), .d3(d3), .d4(d4), .frame_valid(frame_valid), .slot(slot),
        .locked(locked), .sync_err(sync_err), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Model: the partial frame is a queue of words; a frame is published when it holds four.
    logic [W-1:0] q[$];
    logic [W-1:0] ed[4];
    int  idle = 0;
    bit  after_frame = 0;
    bit  efv = 0, elk = 0, eserr = 0, eterr = 0;
    bit  checking = 0;

    always @(posedge clk) begin
        efv = 0; eserr = 0; eterr = 0;
        if (rst) begin
            q.delete();
            idle = 0; after_frame = 0; elk = 0; checking = 1;
            for (int i = 0; i < 4; i++) ed[i] = '0;
        end else if (in_valid) begin
            idle = 0;
            if (in_sof) begin
                if (q.size() != 0) begin eserr = 1; elk = 0; end
                q.delete();
                q.push_back(in_data);
                after_frame = 0;
            end else if (q.size() != 0) begin
                q.push_back(in_data);
                if (q.size() == 4) begin
                    for (int i = 0; i < 4; i++) ed[i] = q[i];
                    efv = 1; elk = 1; after_frame = 1;
                    q.delete();
                end
            end else if (after_frame) begin
                eserr = 1; elk = 0; after_frame = 0;
            end
        end else if (q.size() != 0) begin
            idle++;
            if (idle == GAP) begin
                eterr = 1; elk = 0; idle = 0;
                q.delete();
            end
        end
        #1;
        if (checking) begin
            chk("data", {d1, d2, d3, d4}, {ed[0], ed[1], ed[2], ed[3]});
            chk("frame_valid", frame_valid, efv);
            chk("slot", slot, q.size());
            chk("locked", locked, elk);
            chk("sync_err", sync_err, eserr);
            chk("timeout_err", timeout_err, eterr);
        end
    end

    task automatic step(input bit v, input bit s, input logic [W-1:0] dat, input bit r = 0);
        @(negedge clk);
        in_valid = v; in_sof = s; in_data = dat; rst = r;
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic frame(input logic [W-1:0] a, b, c, d);
        step(1, 1, a); step(1, 0, b); step(1, 0, c); step(1, 0, d);
    endtask

    int pos = 0;

    initial begin
        step(0, 0, 0, 1);
        settle();
        chk("reset_data", {d1, d2, d3, d4}, 16'h0000);
        chk("reset_locked", locked, 0);

        frame(4'h1, 4'h2, 4'h3, 4'h4);
        settle();
        chk("t1_data", {d1, d2, d3, d4}, 16'h1234);
        chk("t1_fv", frame_valid, 1);
        chk("t1_locked", locked, 1);
        step(0, 0, 0);
        settle();
        chk("t1_fv_pulse", frame_valid, 0);

        step(0, 0, 0, 1);
        step(1, 0, 4'h7); step(1, 0, 4'h8);
        frame(4'hA, 4'hB, 4'hC, 4'hD);
        settle();
        chk("t2_data", {d1, d2, d3, d4}, 16'hABCD);

        step(1, 1, 4'h1); step(1, 0, 4'h2); step(1, 1, 4'h5);
        settle();
        chk("t3_sync_err", sync_err, 1);
        chk("t3_hold", {d1, d2, d3, d4}, 16'hABCD);
        step(1, 0, 4'h6); step(1, 0, 4'h7); step(1, 0, 4'h8);
        settle();
        chk("t3_data", {d1, d2, d3, d4}, 16'h5678);

        step(1, 1, 4'h1); step(0, 0, 0); step(0, 0, 0);
        step(1, 0, 4'h2); step(1, 0, 4'h3); step(1, 0, 4'h4);
        settle();
        chk("t4_gap_ok", {d1, d2, d3, d4}, 16'h1234);
        step(1, 1, 4'h1); step(0, 0, 0); step(0, 0, 0); step(0, 0, 0);
        settle();
        chk("t4_timeout", timeout_err, 1);
        chk("t4_unlocked", locked, 0);
        step(1, 0, 4'h2); step(1, 0, 4'h3); step(1, 0, 4'h4);
        settle();
        chk("t4_ignored", {d1, d2, d3, d4}, 16'h1234);

        frame(4'h3, 4'h4, 4'h5, 4'h6);
        step(1, 0, 4'h9);
        settle();
        chk("t5_sync_err", sync_err, 1);
        chk("t5_unlocked", locked, 0);
        chk("t5_hold", {d1, d2, d3, d4}, 16'h3456);
        frame(4'h7, 4'h8, 4'h9, 4'hA);
        settle();
        chk("t5_relock", locked, 1);

        step(1, 1, 4'h1); step(1, 0, 4'h2); step(0, 0, 0, 1);
        step(1, 0, 4'h3); step(1, 0, 4'h4);
        settle();
        chk("t6_data", {d1, d2, d3, d4}, 16'h0000);
        chk("t6_locked", locked, 0);
        chk("t6_fv", frame_valid, 0);

        for (int n = 0; n < 3000; n++) begin
            logic v, s, r;
            r = ($urandom_range(0, 299) == 0);
            v = ($urandom_range(0, 9) < 7);
            s = ((pos % 4) == 0);
            if ($urandom_range(0, 19) == 0) s = ~s;
            if (v) pos++;
            step(v, s, W'($urandom), r);
        end
        step(0, 0, 0);
        settle();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/tdm_demux_1x4.md
Name: tdm_demux_1x4

Overview:
- Receive-end counterpart to the 4-channel TDM multiplexer.
- Accepts a time-multiplexed stream of WIDTH-bit words, one channel per slot. Slot 0 is marked by a start-of-frame flag.
- Steers each word into a per-channel shadow register. Publishes all four channels atomically on d1..d4 with a one-cycle frame_valid strobe.
- Detects frame misalignment and stalled links, and reports lock status.

Parameters:
- WIDTH, 4, data width per channel.
- GAP_LIMIT, 15, number of consecutive idle cycles (in_valid=0) allowed inside a frame before it is aborted; must be >= 1.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  in_data/in_sof are valid this cycle.
- in_sof  input  1  start of frame; qualifies the word as slot 0.
- in_data  input  WIDTH  multiplexed channel word.
- d1  output  WIDTH  channel 0 (slot 0) of the last complete frame.
- d2  output  WIDTH  channel 1 (slot 1) of the last complete frame.
- d3  output  WIDTH  channel 2 (slot 2) of the last complete frame.
- d4  output  WIDTH  channel 3 (slot 3) of the last complete frame.
- frame_valid  output  1  one-cycle pulse; d1..d4 updated this cycle.
- slot  output  2  index of the next expected slot.
- locked  output  1  at least one complete frame received since the last error or reset.
- sync_err  output  1  one-cycle pulse; SOF misplaced or missing.
- timeout_err  output  1  one-cycle pulse; gap limit hit mid-frame.

Behaviour:
- Reset is synchronous. The cycle after rst is sampled high:
  - state=HUNT, slot=0, gap counter=0.
  - d1..d4=0, frame_valid=0, locked=0, sync_err=0, timeout_err=0.
  - Any partial frame is discarded. Reset has priority over all other events.
- All outputs are registered. A word is accepted at a rising edge with in_valid=1.
- HUNT state:
  - in_valid=1, in_sof=0: word discarded, no error.
  - in_valid=1, in_sof=1: shadow[0]<=in_data, slot<=1, go to COLLECT.
- COLLECT state:
  - in_valid=1, in_sof=0: shadow[slot]<=in_data, slot<=slot+1, gap counter cleared.
  - Completing word (accepted at slot 3), at the same edge:
    - d1..d4 <= shadow[0..2] and the current in_data.
    - frame_valid=1 for exactly one cycle.
    - locked<=1, slot<=0, go to ALIGNED.
  - in_valid=1, in_sof=1 (early SOF at slot 1..3):
    - sync_err pulses, locked<=0, partial frame discarded.
    - The word is taken as the new slot 0: shadow[0]<=in_data, slot<=1, stay in COLLECT.
  - in_valid=0: gap counter increments.
    - When it would reach GAP_LIMIT: timeout_err pulses, locked<=0, partial frame discarded, slot<=0, go to HUNT.
    - Exactly GAP_LIMIT-1 consecutive idle cycles is tolerated.
- ALIGNED state (expecting the next SOF):
  - in_valid=1, in_sof=1: behaves as HUNT acceptance (go to COLLECT, slot=1).
  - in_valid=1, in_sof=0: sync_err pulses, locked<=0, word discarded, go to HUNT.
  - Idle cycles in ALIGNED and HUNT are unlimited; no timeout.
- Output holding:
  - d1..d4 change only on frame completion (or reset), and all four update together.
  - d1..d4 hold their values across errors and idle periods.
- Latency: the 4th word is accepted at edge k; d1..d4 and frame_valid are visible after edge k.
- Back-to-back frames at full rate (16 consecutive valid words, SOF every 4th) produce frame_valid every 4th cycle with no gaps and no errors.
- sync_err and timeout_err never assert in the same cycle. An accepted word clears the gap counter before the timeout check.
- Gap counter width is clog2(GAP_LIMIT+1) bits; it saturates and never wraps.

Test Plan:
- Reset, then SOF+0x1, 0x2, 0x3, 0x4 on consecutive cycles:
  - d1=1, d2=2, d3=3, d4=4 and frame_valid=1 for one cycle after the 4th edge.
  - locked=1, no errors.
- In HUNT, send 0x7, 0x8 without SOF, then SOF frame 0xA, 0xB, 0xC, 0xD:
  - The first two words are ignored.
  - d1..d4=A, B, C, D; no sync_err.
- SOF+0x1, 0x2, then SOF+0x5, 0x6, 0x7, 0x8:
  - sync_err pulses once when the second SOF arrives.
  - Resulting frame: d1..d4=5, 6, 7, 8.
  - Previously held d values are unchanged until that frame completes.
- GAP_LIMIT=3:
  - SOF+1, idle 2 cycles, 2, 3, 4: frame completes, no timeout.
  - SOF+1, idle 3 cycles: timeout_err pulses, locked=0, no frame_valid.
  - A subsequent 2, 3, 4 without SOF is ignored.
- After lock, send a 0x9 word without SOF where a SOF is expected:
  - sync_err=1, locked=0, d1..d4 hold the prior frame.
  - The next SOF frame relocks.
- Mid-frame reset: SOF+1, 2, rst=1 for one cycle, then 3, 4:
  - d1..d4=0 and locked=0.
  - No frame_valid until a new SOF-led frame completes.
